// File: rtl/dice_meas_pkg.sv
// dice_meas_pkg: shared types and sizing helpers for the DICE measurement sequencer
package dice_meas_pkg;

    localparam int DICE_CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SAMPLE,
        RESULT,
        HOLD
    } meas_seq_state_t;

    function automatic int acc_width(input int cnt_width, input int log2_samples);
        return cnt_width + log2_samples;
    endfunction

endpackage

// File: rtl/dice_meas_accum.sv
// dice_meas_accum: sample accumulator, zero counter and optional min/max tracker (DICE_MEAS_SEQ_MINMAX_EN)
module dice_meas_accum
    import dice_meas_pkg::*;
#(
    parameter int CNT_WIDTH    = DICE_CNT_WIDTH,
    parameter int LOG2_SAMPLES = 3
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         clr,
    input  logic                                         en,
    input  logic [CNT_WIDTH-1:0]                         sample,
    output logic [acc_width(CNT_WIDTH, LOG2_SAMPLES)-1:0] acc,
    output logic [CNT_WIDTH-1:0]                         run_min,
    output logic [CNT_WIDTH-1:0]                         run_max,
    output logic [LOG2_SAMPLES:0]                        zeros
);

    localparam int AW = acc_width(CNT_WIDTH, LOG2_SAMPLES);

    // sum every sample and count the ones where the ring never completed
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc   <= '0;
            zeros <= '0;
        end else if (en) begin
            acc   <= acc + AW'(sample);
            zeros <= zeros + (LOG2_SAMPLES + 1)'(sample == '0);
        end
    end

`ifdef DICE_MEAS_SEQ_MINMAX_EN
    logic [CNT_WIDTH-1:0] mn, mx;

    // running extremes; min starts at all-ones so the first sample always wins
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            mn <= '1;
            mx <= '0;
        end else if (en) begin
            if (sample < mn) mn <= sample;
            if (sample > mx) mx <= sample;
        end
    end

    assign run_min = mn;
    assign run_max = mx;
`else
    assign run_min = '0;
    assign run_max = '0;
`endif

endmodule

// File: rtl/dice_meas_sequencer.sv
// dice_meas_sequencer: runs averaged ring-measurement bursts; min/max tracking gated by DICE_MEAS_SEQ_MINMAX_EN
module dice_meas_sequencer
    import dice_meas_pkg::*;
#(
    parameter int CNT_WIDTH    = DICE_CNT_WIDTH,
    parameter int LOG2_SAMPLES = 3,
    parameter int START_CYCLES = 2,
    parameter int WAIT_CYCLES  = 300
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    output logic                  busy,
    output logic                  meas_start,
    input  logic [CNT_WIDTH-1:0]  measured_cnt,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CNT_WIDTH-1:0]  avg_cnt,
    output logic [CNT_WIDTH-1:0]  min_cnt,
    output logic [CNT_WIDTH-1:0]  max_cnt,
    output logic [LOG2_SAMPLES:0] zero_cnt
);

    localparam int AW = acc_width(CNT_WIDTH, LOG2_SAMPLES);
    localparam int TW = $clog2((WAIT_CYCLES > START_CYCLES ? WAIT_CYCLES : START_CYCLES) + 1);
    localparam int IW = LOG2_SAMPLES + 1;
    localparam logic [IW-1:0] LAST  = IW'((1 << LOG2_SAMPLES) - 1);
    localparam logic [TW-1:0] S_END = TW'(START_CYCLES - 1);
    localparam logic [TW-1:0] W_END = TW'(WAIT_CYCLES - 1);

    meas_seq_state_t      state, next;
    logic [TW-1:0]        tmr;
    logic [IW-1:0]        idx;
    logic [AW-1:0]        acc;
    logic [CNT_WIDTH-1:0] run_min, run_max;
    logic [LOG2_SAMPLES:0] zeros;

    dice_meas_accum #(
        .CNT_WIDTH   (CNT_WIDTH),
        .LOG2_SAMPLES(LOG2_SAMPLES)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == IDLE),
        .en     (state == SAMPLE),
        .sample (measured_cnt),
        .acc    (acc),
        .run_min(run_min),
        .run_max(run_max),
        .zeros  (zeros)
    );

    // next-state decode; req only matters in IDLE
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req ? START : IDLE;
            START:   next = (tmr == S_END) ? WAIT : START;
            WAIT:    next = (tmr == W_END) ? SAMPLE : WAIT;
            SAMPLE:  next = (idx == LAST) ? RESULT : START;
            RESULT:  next = HOLD;
            HOLD:    next = (res_valid && res_ready) ? IDLE : HOLD;
            default: next = IDLE;
        endcase
    end

    // state, phase timer, sample index and registered control outputs derived from next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            idx        <= '0;
            meas_start <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            state      <= next;
            tmr        <= (next != state) ? '0 : tmr + TW'(1);
            idx        <= (state == IDLE) ? '0 : (state == SAMPLE && idx != LAST) ? idx + IW'(1) : idx;
            meas_start <= next == START;
            busy       <= next == START || next == WAIT || next == SAMPLE || next == RESULT;
            res_valid  <= next == HOLD;
        end
    end

    // result registers load once per burst and hold until the next one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avg_cnt  <= '0;
            min_cnt  <= '0;
            max_cnt  <= '0;
            zero_cnt <= '0;
        end else if (state == RESULT) begin
            avg_cnt  <= CNT_WIDTH'(acc >> LOG2_SAMPLES);
            min_cnt  <= run_min;
            max_cnt  <= run_max;
            zero_cnt <= zeros;
        end
    end

endmodule

// File: tb/tb_dice_meas_sequencer.sv
// tb_dice_meas_sequencer: scoreboard bench for the measurement sequencer with a stub ring model
module tb_dice_meas_sequencer;

    localparam int L2 = 3;
    localparam int NS = 1 << L2;
    localparam int SC = 2;
    localparam int WC = 300;
    localparam int LAT = NS * (SC + WC + 1) + 1;
`ifdef DICE_MEAS_SEQ_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        busy;
    logic        meas_start;
    logic [7:0]  measured_cnt = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  avg_cnt, min_cnt, max_cnt;
    logic [L2:0] zero_cnt;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int vals[NS];
    int pidx = 0;
    bit ms_prev = 1'b0;

    typedef struct {
        int avg;
        int mn;
        int mx;
        int zr;
    } exp_t;
    exp_t q[$];

    dice_meas_sequencer #(
        .CNT_WIDTH   (8),
        .LOG2_SAMPLES(L2),
        .START_CYCLES(SC),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .busy        (busy),
        .meas_start  (meas_start),
        .measured_cnt(measured_cnt),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .avg_cnt     (avg_cnt),
        .min_cnt     (min_cnt),
        .max_cnt     (max_cnt),
        .zero_cnt    (zero_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // stub ring: each new start pulse presents the next table value
    always @(negedge clk) begin
        if (!busy) pidx = 0;
        else if (meas_start && !ms_prev) begin
            if (pidx < NS) measured_cnt = 8'(vals[pidx]);
            pidx++;
        end
        ms_prev = meas_start;
    end

    // scoreboard monitor: compare each handshaked result with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_result: got avg %0d expected no result", avg_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("avg_cnt", int'(avg_cnt), e.avg);
                check("min_cnt", int'(min_cnt), e.mn);
                check("max_cnt", int'(max_cnt), e.mx);
                check("zero_cnt", int'(zero_cnt), e.zr);
            end
        end
    end

    // start pulse shape: width, in-burst spacing and pulse count per burst
    int hi = 0, lo = 0, np = 0;
    bit rv_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hi = 0;
            lo = 0;
            np = 0;
        end else begin
            if (meas_start) begin
                if (lo != 0 && np > 0 && busy) check("start_gap", lo, WC + 1);
                hi++;
                lo = 0;
            end else begin
                if (hi != 0) begin
                    check("start_width", hi, SC);
                    np++;
                end
                hi = 0;
                lo++;
            end
            if (res_valid && !rv_prev) check("pulse_count", np, NS);
            if (!busy) np = 0;
        end
        rv_prev = res_valid;
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LAT + 100 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL res_valid_timeout: got no res_valid expected one within %0d cycles", LAT + 100);
        end
    endtask

    task automatic run(input int e_avg, input int e_mn, input int e_mx, input int e_zr, input int hold);
        exp_t e;
        int   start_cyc;
        bit   ok;
        bit   stable;
        e.avg = e_avg;
        e.mn  = MM ? e_mn : 0;
        e.mx  = MM ? e_mx : 0;
        e.zr  = e_zr;
        q.push_back(e);
        res_ready = (hold == 0);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        req = 1'b0;
        check("busy_on_accept", int'(busy), 1);
        wait_valid(ok);
        check("latency", cyc - start_cyc, LAT);
        if (hold > 0) begin
            stable = 1'b1;
            req = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!res_valid || busy || meas_start || int'(avg_cnt) != e.avg || int'(min_cnt) != e.mn ||
                    int'(max_cnt) != e.mx || int'(zero_cnt) != e.zr)
                    stable = 1'b0;
            end
            check("hold_stable", int'(stable), 1);
            @(posedge clk);
            #1;
            req = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check("res_valid_after_accept", int'(res_valid), 0);
        check("busy_after_accept", int'(busy), 0);
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_meas_start", int'(meas_start), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_avg", int'(avg_cnt), 0);
        check("rst_min", int'(min_cnt), 0);
        check("rst_max", int'(max_cnt), 0);
        check("rst_zero", int'(zero_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vals = '{10, 20, 30, 41, 10, 20, 30, 41};
        run(25, 10, 41, 0, 0);

        vals = '{100, 100, 0, 100, 100, 0, 100, 100};
        run(75, 0, 100, 2, 0);

        vals = '{5, 6, 7, 8, 9, 10, 11, 12};
        run(8, 5, 12, 0, 50);

        vals = '{200, 200, 200, 200, 200, 200, 200, 200};
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4 * (SC + WC + 1) + 10 && !ok; i++) begin
            @(negedge clk);
            ok = (pidx == 4) && !meas_start;
        end
        check("reached_sample4_wait", int'(ok), 1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_meas_start", int'(meas_start), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_res_valid", int'(res_valid), 0);
        check("midrst_avg", int'(avg_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vals = '{50, 51, 52, 53, 54, 55, 56, 57};
        run(53, 50, 57, 0, 0);

        vals = '{255, 255, 255, 255, 255, 255, 255, 255};
        run(255, 255, 255, 0, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dice_meas_sequencer.md
Name: dice_meas_sequencer

Overview:
- Control and post-processing stage that sits directly downstream of the DICE DFF clk-to-q/setup ring measurement.
- On each request it runs 2**LOG2_SAMPLES measurements by pulsing the ring's start input, then waits a fixed settle window and samples the ring's measured_cnt.
- It accumulates the samples and presents the average, min, max and zero-sample count through a valid/ready result handshake.

Parameters:
- CNT_WIDTH, 8: width of measured_cnt from the ring; must match the ring instance.
- LOG2_SAMPLES, 3: log2 of samples per request; default gives 8 samples. Range 0..6.
- START_CYCLES, 2: cycles meas_start is held high per sample. Must be >= 1.
- WAIT_CYCLES, 300: settle cycles after start deasserts before sampling. Must be >= 2**CNT_WIDTH+N_ring so the ring counter has finished.

Ports:
- clk, input, 1: single clock, shared with the ring.
- rst_n, input, 1: synchronous active-low reset.
- req, input, 1: level/pulse request for a measurement burst.
- busy, output, 1: high from request acceptance until res_valid rises.
- meas_start, output, 1: drives the ring's start input. Registered.
- measured_cnt, input, CNT_WIDTH: result from the ring.
- res_valid, output, 1: result available.
- res_ready, input, 1: consumer accepts the result.
- avg_cnt, output, CNT_WIDTH: truncated mean of the samples.
- min_cnt, output, CNT_WIDTH: smallest sample.
- max_cnt, output, CNT_WIDTH: largest sample.
- zero_cnt, output, LOG2_SAMPLES+1: number of samples equal to 0 (ring never completed).

Behaviour:
- Reset: rst_n low at a posedge forces state IDLE. All outputs go to 0 (busy, meas_start, res_valid, avg/min/max/zero_cnt). Internal accumulator, sample index and wait counter clear.
- Reset mid-burst: abandons the burst; meas_start is low after that edge. No partial result is produced.
- States: IDLE, START, WAIT, SAMPLE, RESULT, HOLD.
- IDLE:
  - req=1 -> START and busy=1.
  - Clears acc=0, run_min=all-ones, run_max=0, zeros=0, idx=0.
  - req is ignored in every state except IDLE.
- START: meas_start=1 for exactly START_CYCLES consecutive cycles, then -> WAIT.
- WAIT: meas_start=0; counts WAIT_CYCLES cycles, then -> SAMPLE.
- SAMPLE (1 cycle):
  - acc += measured_cnt; update run_min/run_max.
  - If measured_cnt==0, zeros++. Zero samples are still included in acc/min/max.
  - If idx==2**LOG2_SAMPLES-1 -> RESULT; else idx++ and -> START.
- RESULT (1 cycle): loads avg_cnt=acc>>LOG2_SAMPLES (truncate), min_cnt, max_cnt, zero_cnt; res_valid=1, busy=0 -> HOLD.
- HOLD: outputs stable while res_valid=1. On res_valid&&res_ready -> IDLE and res_valid=0 next cycle. Result registers keep their values until the next RESULT.
- Latency: the req-sampling edge enters START. res_valid rises 2**LOG2_SAMPLES*(START_CYCLES+WAIT_CYCLES+1)+1 cycles later.
- Arithmetic:
  - acc width CNT_WIDTH+LOG2_SAMPLES; cannot overflow.
  - Wait counter width $clog2(WAIT_CYCLES+1).
  - LOG2_SAMPLES=0: single sample, avg=min=max=sample.
- Back-to-back: req held high during HOLD while res_ready=1 starts the next burst no earlier than the cycle after the return to IDLE.

Optional Feature:
- Macro DICE_MEAS_SEQ_MINMAX_EN.
- Defined: run_min/run_max are tracked and output as specified.
- Undefined: no min/max registers or comparators are built; min_cnt and max_cnt are constant 0. Ports remain present.

Decomposition:
- Package dice_meas_pkg:
  - enum meas_seq_state_t (IDLE, START, WAIT, SAMPLE, RESULT, HOLD);
  - localparam helper function for acc width;
  - default CNT_WIDTH constant shared with the ring.
- One sub-module, dice_meas_accum: accumulator, min/max (macro-gated), zero counter, with clear/sample-enable inputs. The FSM stays in the top.

Test Plan:
- Basic average: LOG2_SAMPLES=2; stub returns 10,20,30,41 -> avg_cnt=25, min=10, max=41, zero_cnt=0. res_valid at latency 4*(2+300+1)+1=1213 cycles.
- Start pulse shape: burst of 8 -> exactly 8 meas_start pulses, each 2 cycles wide, 301 cycles apart low.
- Zero samples: stub returns 0 on samples 3 and 6, else 100 -> zero_cnt=2, min=0, avg=75.
- Backpressure: res_ready=0 for 50 cycles after res_valid -> outputs stable, req ignored. res_ready=1 -> res_valid low next cycle, state IDLE.
- Reset mid-burst: rst_n low during WAIT of sample 4 -> next edge meas_start=0, busy=0, res_valid=0. A new req runs a full 8-sample burst.
- Macro off: same stimulus as the basic-average case -> avg_cnt=25, min_cnt=max_cnt=0.
